// File: rtl/single_cpu_pkg.sv
// rtl/single_cpu_pkg.sv - shared fetch-stage types and constants
//
// Purpose : state encoding of the single-entry fetch FSM, the word used in
//           place of an instruction when a fetch faults, and a small
//           alignment helper shared by the CPU front-end blocks.
// Ports   : none (package).

package single_cpu_pkg;

  // Two-bit encoding of the fetch FSM.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,  // no entry held, ready for a new fetch address
    ST_REQ   = 2'd1,  // memory request outstanding for the held address
    ST_FULL  = 2'd2,  // entry (instruction or fault) presented to decode
    ST_DRAIN = 2'd3   // flushed while a request was outstanding
  } fetch_state_e;

  // Instruction word presented alongside a misaligned-fetch fault.
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  // Instruction fetches must be word aligned.
  function automatic logic is_misaligned(input logic [1:0] addr_lsb);
    return addr_lsb != 2'b00;
  endfunction

endpackage

// File: rtl/single_ifetch.sv
// rtl/single_ifetch.sv - single-entry instruction fetch stage
//
// Purpose : accepts one fetch address at a time from the PC stage, issues a
//           request to instruction memory, and presents the returned word
//           (or a misaligned-fetch fault) to decode. A new address can be
//           accepted in the same cycle the held entry transfers, so aligned
//           fetches with single-cycle memory sustain one instruction per two
//           cycles. A flush with a request outstanding waits for the memory
//           to answer (DRAIN) and discards the returned word.
//
// Ports   : clk, rst          - clock, asynchronous active-low reset
//           i_pc, i_pc_valid  - fetch address from the PC stage
//           o_pc_ready        - fetch address accepted this cycle
//           o_imem_req/addr   - instruction-memory request and address
//           i_imem_ack/rdata  - memory completion and instruction word
//           o_valid, i_ready  - handshake towards decode
//           o_instr/instr_pc  - instruction word and its address
//           o_fault           - presented entry is a misaligned-fetch fault
//           i_flush           - discard all in-flight fetch work
//           o_fetch_cnt       - delivered non-fault instructions (wraps)

module single_ifetch
  import single_cpu_pkg::*;
#(
  parameter int          N        = 32,
  parameter logic [N-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] i_pc,
  input  logic         i_pc_valid,
  output logic         o_pc_ready,
  output logic         o_imem_req,
  output logic [N-1:0] o_imem_addr,
  input  logic         i_imem_ack,
  input  logic [N-1:0] i_imem_rdata,
  output logic         o_valid,
  input  logic         i_ready,
  output logic [N-1:0] o_instr,
  output logic [N-1:0] o_instr_pc,
  output logic         o_fault,
  input  logic         i_flush,
  output logic [15:0]  o_fetch_cnt
);

  fetch_state_e state_q, state_d;

  logic         imem_req_q,  imem_req_d;
  logic [N-1:0] imem_addr_q, imem_addr_d;
  logic [N-1:0] instr_q,     instr_d;
  logic [N-1:0] instr_pc_q,  instr_pc_d;
  logic         fault_q,     fault_d;
  logic [15:0]  fetch_cnt_q, fetch_cnt_d;

  logic pc_ready;
  logic pc_accept;
  logic pc_misaligned;
  logic mem_done;
  logic deliver;

  assign pc_accept     = i_pc_valid && pc_ready;
  assign pc_misaligned = is_misaligned(i_pc[1:0]);
  // Memory answer for a live (not flushed) request.
  assign mem_done      = (state_q == ST_REQ) && i_imem_ack && !i_flush;
  // Held entry leaves towards decode; a flush in the same cycle drops it.
  assign deliver       = (state_q == ST_FULL) && i_ready && !i_flush;

  // ---------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (pc_accept) begin
          state_d = pc_misaligned ? ST_FULL : ST_REQ;
        end
      end
      ST_REQ: begin
        // A flush that coincides with the ack has nothing left to drain.
        if (i_flush) begin
          state_d = i_imem_ack ? ST_IDLE : ST_DRAIN;
        end else if (i_imem_ack) begin
          state_d = ST_FULL;
        end
      end
      ST_FULL: begin
        if (i_flush) begin
          state_d = ST_IDLE;
        end else if (i_ready) begin
          if (pc_accept) begin
            state_d = pc_misaligned ? ST_FULL : ST_REQ;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_DRAIN: begin
        if (i_imem_ack) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------
  // FSM: outputs decoded from state
  // ---------------------------------------------------------------------
  always_comb begin
    o_valid  = (state_q == ST_FULL);
    pc_ready = !i_flush && ((state_q == ST_IDLE) ||
                            ((state_q == ST_FULL) && i_ready));
  end

  assign o_pc_ready = pc_ready;

  // ---------------------------------------------------------------------
  // Datapath next values
  // ---------------------------------------------------------------------
  always_comb begin
    imem_addr_d = imem_addr_q;
    instr_d     = instr_q;
    instr_pc_d  = instr_pc_q;
    fault_d     = fault_q;

    // Request is a registered function of where the FSM goes next, so it
    // rises the cycle after accept and stays up through REQ/DRAIN.
    imem_req_d  = (state_d == ST_REQ) || (state_d == ST_DRAIN);

    if (pc_accept) begin
      imem_addr_d = i_pc;
      instr_pc_d  = i_pc;
      if (pc_misaligned) begin
        fault_d = 1'b1;
        instr_d = N'(NOP_INSTR);
      end else begin
        fault_d = 1'b0;
      end
    end

    if (mem_done) begin
      instr_d = i_imem_rdata;
      fault_d = 1'b0;
    end

    fetch_cnt_d = fetch_cnt_q;
    if (deliver && !fault_q) begin
      fetch_cnt_d = fetch_cnt_q + 16'd1;
    end
  end

  // ---------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      imem_req_q  <= 1'b0;
      imem_addr_q <= '0;
      instr_q     <= '0;
      instr_pc_q  <= RESET_PC;
      fault_q     <= 1'b0;
      fetch_cnt_q <= 16'd0;
    end else begin
      imem_req_q  <= imem_req_d;
      imem_addr_q <= imem_addr_d;
      instr_q     <= instr_d;
      instr_pc_q  <= instr_pc_d;
      fault_q     <= fault_d;
      fetch_cnt_q <= fetch_cnt_d;
    end
  end

  assign o_imem_req  = imem_req_q;
  assign o_imem_addr = imem_addr_q;
  assign o_instr     = instr_q;
  assign o_instr_pc  = instr_pc_q;
  assign o_fault     = fault_q;
  assign o_fetch_cnt = fetch_cnt_q;

endmodule

// File: tb/tb_single_ifetch.sv
// tb/tb_single_ifetch.sv - self-checking bench for single_ifetch

module tb_single_ifetch;

  localparam int          N      = 32;
  localparam logic [31:0] RST_PC = 32'h0000_0100;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  i_pc;
  logic          i_pc_valid;
  logic          o_pc_ready;
  logic          o_imem_req;
  logic [N-1:0]  o_imem_addr;
  logic          i_imem_ack;
  logic [N-1:0]  i_imem_rdata;
  logic          o_valid;
  logic          i_ready;
  logic [N-1:0]  o_instr;
  logic [N-1:0]  o_instr_pc;
  logic          o_fault;
  logic          i_flush;
  logic [15:0]   o_fetch_cnt;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [15:0] exp_cnt  = 16'd0;

  typedef struct {
    logic [31:0] pc;
    logic        fault;
    logic [31:0] instr;
  } entry_t;

  entry_t exp_q[$];

  single_ifetch #(.N(N), .RESET_PC(RST_PC)) dut (
    .clk         (clk),
    .rst         (rst),
    .i_pc        (i_pc),
    .i_pc_valid  (i_pc_valid),
    .o_pc_ready  (o_pc_ready),
    .o_imem_req  (o_imem_req),
    .o_imem_addr (o_imem_addr),
    .i_imem_ack  (i_imem_ack),
    .i_imem_rdata(i_imem_rdata),
    .o_valid     (o_valid),
    .i_ready     (i_ready),
    .o_instr     (o_instr),
    .o_instr_pc  (o_instr_pc),
    .o_fault     (o_fault),
    .i_flush     (i_flush),
    .o_fetch_cnt (o_fetch_cnt)
  );

  always #5 clk = ~clk;

  // Memory contents: any fixed function of the word address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; i_pc = '0; i_pc_valid = 0; i_imem_ack = 0; i_imem_rdata = '0;
    i_ready = 0; i_flush = 0;
    #23;
    n_checks++;
    if ({o_imem_req, o_valid, o_fault} !== 3'b000) begin
      n_errors++; $display("FAIL reset_flags got %b exp 000", {o_imem_req, o_valid, o_fault});
    end
    n_checks++;
    if ({o_imem_addr, o_instr, o_instr_pc} !== {32'h0, 32'h0, RST_PC}) begin
      n_errors++; $display("FAIL reset_regs got %h/%h/%h exp 0/0/%h", o_imem_addr, o_instr, o_instr_pc, RST_PC);
    end
    n_checks++;
    if (o_fetch_cnt !== 16'd0) begin
      n_errors++; $display("FAIL reset_cnt got %0d exp 0", o_fetch_cnt);
    end
    tick(); rst = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({o_pc_ready, o_valid} !== 2'b10) begin
      n_errors++; $display("FAIL reset_release got %b exp 10", {o_pc_ready, o_valid});
    end
  endtask

  task automatic test_basic();
    tick(); i_pc = 32'h10; i_pc_valid = 1;
    tick(); i_pc_valid = 0;
    for (int k = 0; k < 3; k++) begin
      if (k == 2) begin i_imem_ack = 1; i_imem_rdata = 32'h2002_0005; end
      @(negedge clk);
      n_checks++;
      if ({o_imem_req, o_valid, o_imem_addr} !== {2'b10, 32'h10}) begin
        n_errors++; $display("FAIL basic_req c%0d got req=%b valid=%b addr=%h exp 1 0 10", k, o_imem_req, o_valid, o_imem_addr);
      end
      if (k < 2) tick();
    end
    tick(); i_imem_ack = 0; i_imem_rdata = 32'h0;
    @(negedge clk);
    n_checks++;
    if ({o_valid, o_fault, o_imem_req, o_instr, o_instr_pc} !== {3'b100, 32'h2002_0005, 32'h10}) begin
      n_errors++; $display("FAIL basic_deliver got v=%b f=%b req=%b instr=%h pc=%h", o_valid, o_fault, o_imem_req, o_instr, o_instr_pc);
    end
    tick(); i_ready = 1;
    tick(); i_ready = 0; exp_cnt++;
    @(negedge clk);
    n_checks++;
    if ({o_valid, o_fetch_cnt} !== {1'b0, exp_cnt}) begin
      n_errors++; $display("FAIL basic_cnt got v=%b cnt=%0d exp 0 %0d", o_valid, o_fetch_cnt, exp_cnt);
    end
  endtask

  task automatic test_stall();
    tick(); i_pc = 32'h20; i_pc_valid = 1;
    tick(); i_pc_valid = 0; i_imem_ack = 1; i_imem_rdata = 32'h0BAD_F00D;
    tick(); i_imem_ack = 0; i_pc = 32'h24; i_pc_valid = 1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      n_checks++;
      if ({o_valid, o_fault, o_pc_ready, o_imem_req, o_instr, o_instr_pc} !==
          {4'b1000, 32'h0BAD_F00D, 32'h20}) begin
        n_errors++; $display("FAIL stall_hold c%0d got v=%b f=%b rdy=%b req=%b instr=%h pc=%h", k, o_valid, o_fault, o_pc_ready, o_imem_req, o_instr, o_instr_pc);
      end
      tick();
    end
    i_pc_valid = 0; i_ready = 1;
    tick(); i_ready = 0; exp_cnt++;
    @(negedge clk);
    n_checks++;
    if ({o_valid, o_imem_req, o_fetch_cnt} !== {2'b00, exp_cnt}) begin
      n_errors++; $display("FAIL stall_release got v=%b req=%b cnt=%0d exp 0 0 %0d", o_valid, o_imem_req, o_fetch_cnt, exp_cnt);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] pcs [3];
    int idx = 0, deliv = 0, last_c = 0, acc0 = 0;
    entry_t e;
    pcs[0] = 32'h0; pcs[1] = 32'h4; pcs[2] = 32'h8;
    i_ready = 1;
    for (int c = 0; c < 20 && deliv < 3; c++) begin
      tick();
      i_imem_ack   = o_imem_req;
      i_imem_rdata = mem_word(o_imem_addr);
      i_pc_valid   = (idx < 3);
      i_pc         = (idx < 3) ? pcs[idx] : 32'h0;
      @(negedge clk);
      if (o_valid && i_ready) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_errors++; $display("FAIL b2b_extra got pc=%h exp none", o_instr_pc);
        end else begin
          e = exp_q.pop_front();
          if ({o_instr, o_instr_pc, o_fault} !== {e.instr, e.pc, e.fault}) begin
            n_errors++; $display("FAIL b2b_entry got %h@%h exp %h@%h", o_instr, o_instr_pc, e.instr, e.pc);
          end
        end
        n_checks++;
        if ((deliv == 0 ? c - acc0 : c - last_c) != 2) begin
          n_errors++; $display("FAIL b2b_spacing got %0d cycles exp 2", deliv == 0 ? c - acc0 : c - last_c);
        end
        last_c = c; deliv++; exp_cnt++;
      end
      if (i_pc_valid && o_pc_ready) begin
        exp_q.push_back('{pc: pcs[idx], fault: 1'b0, instr: mem_word(pcs[idx])});
        if (idx == 0) acc0 = c;
        idx++;
      end
    end
    n_checks++;
    if (deliv != 3 || exp_q.size() != 0) begin
      n_errors++; $display("FAIL b2b_count got %0d delivered %0d left exp 3 0", deliv, exp_q.size());
    end
    exp_q.delete();
    tick(); i_ready = 0; i_pc_valid = 0; i_imem_ack = 0;
    @(negedge clk);
    n_checks++;
    if (o_fetch_cnt !== exp_cnt) begin
      n_errors++; $display("FAIL b2b_cnt got %0d exp %0d", o_fetch_cnt, exp_cnt);
    end
  endtask

  task automatic test_fault();
    logic saw_req = 0;
    tick(); i_pc = 32'h6; i_pc_valid = 1;
    tick(); i_pc_valid = 0;
    @(negedge clk);
    n_checks++;
    if ({o_valid, o_fault, o_instr, o_instr_pc} !== {2'b11, 32'h0, 32'h6}) begin
      n_errors++; $display("FAIL fault_entry got v=%b f=%b instr=%h pc=%h exp 1 1 0 6", o_valid, o_fault, o_instr, o_instr_pc);
    end
    for (int k = 0; k < 4; k++) begin
      saw_req |= o_imem_req;
      tick();
      i_ready = (k == 1);
      @(negedge clk);
    end
    saw_req |= o_imem_req;
    n_checks++;
    if (saw_req !== 1'b0) begin
      n_errors++; $display("FAIL fault_no_req got req seen exp never");
    end
    n_checks++;
    if ({o_valid, o_fetch_cnt} !== {1'b0, exp_cnt}) begin
      n_errors++; $display("FAIL fault_cnt got v=%b cnt=%0d exp 0 %0d", o_valid, o_fetch_cnt, exp_cnt);
    end
    i_ready = 0;
  endtask

  task automatic test_flush();
    logic saw_valid = 0;
    tick(); i_pc = 32'h30; i_pc_valid = 1;
    tick(); i_pc_valid = 0;
    tick(); i_flush = 1;
    @(negedge clk);
    saw_valid |= o_valid;
    n_checks++;
    if ({o_imem_req, o_pc_ready} !== 2'b10) begin
      n_errors++; $display("FAIL flush_req got req=%b rdy=%b exp 1 0", o_imem_req, o_pc_ready);
    end
    tick();
    @(negedge clk);
    saw_valid |= o_valid;
    n_checks++;
    if (o_imem_req !== 1'b1) begin
      n_errors++; $display("FAIL flush_drain_req got %b exp 1", o_imem_req);
    end
    tick(); i_flush = 0; i_imem_ack = 1; i_imem_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    saw_valid |= o_valid;
    tick(); i_imem_ack = 0;
    @(negedge clk);
    saw_valid |= o_valid;
    n_checks++;
    if ({saw_valid, o_imem_req, o_pc_ready} !== 3'b001) begin
      n_errors++; $display("FAIL flush_idle got seen_valid=%b req=%b rdy=%b exp 0 0 1", saw_valid, o_imem_req, o_pc_ready);
    end
    n_checks++;
    if (o_instr === 32'hDEAD_BEEF || o_fetch_cnt !== exp_cnt) begin
      n_errors++; $display("FAIL flush_discard got instr=%h cnt=%0d exp not DEADBEEF and %0d", o_instr, o_fetch_cnt, exp_cnt);
    end
  endtask

  task automatic test_random();
    entry_t e;
    logic [31:0] pc;
    for (int c = 0; c < 400; c++) begin
      tick();
      i_imem_ack   = o_imem_req ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 7) == 0);
      i_imem_rdata = o_imem_req ? mem_word(o_imem_addr) : $urandom;
      pc = $urandom;
      if ($urandom_range(0, 4) != 0) pc[1:0] = 2'b00;
      else if (pc[1:0] == 2'b00) pc[1:0] = 2'b10;
      i_pc       = pc;
      i_pc_valid = ($urandom_range(0, 3) != 0);
      i_ready    = ($urandom_range(0, 2) != 0);
      @(negedge clk);
      n_checks++;
      if (o_fetch_cnt !== exp_cnt) begin
        n_errors++; $display("FAIL rand_cnt c%0d got %0d exp %0d", c, o_fetch_cnt, exp_cnt);
      end
      n_checks++;
      if (o_pc_ready !== (exp_q.size() == 0 || (o_valid && i_ready)) ||
          (exp_q.size() == 0 && o_valid)) begin
        n_errors++; $display("FAIL rand_hs c%0d got rdy=%b v=%b pending=%0d", c, o_pc_ready, o_valid, exp_q.size());
      end
      if (o_valid && i_ready && exp_q.size() != 0) begin
        e = exp_q.pop_front();
        n_checks++;
        if ({o_instr, o_instr_pc, o_fault} !== {e.instr, e.pc, e.fault}) begin
          n_errors++; $display("FAIL rand_entry c%0d got %h@%h f=%b exp %h@%h f=%b", c, o_instr, o_instr_pc, o_fault, e.instr, e.pc, e.fault);
        end
        if (!e.fault) exp_cnt++;
      end
      if (i_pc_valid && o_pc_ready) begin
        exp_q.push_back('{pc: pc, fault: (pc[1:0] != 2'b00),
                          instr: (pc[1:0] != 2'b00) ? 32'h0 : mem_word(pc)});
      end
    end
    // Let the last entry out with a cooperative memory and decode.
    for (int c = 0; c < 60 && exp_q.size() != 0; c++) begin
      tick();
      i_pc_valid = 0; i_ready = 1;
      i_imem_ack = o_imem_req; i_imem_rdata = mem_word(o_imem_addr);
      @(negedge clk);
      if (o_valid && i_ready && exp_q.size() != 0) begin
        e = exp_q.pop_front();
        n_checks++;
        if ({o_instr, o_instr_pc, o_fault} !== {e.instr, e.pc, e.fault}) begin
          n_errors++; $display("FAIL rand_drain got %h@%h exp %h@%h", o_instr, o_instr_pc, e.instr, e.pc);
        end
        if (!e.fault) exp_cnt++;
      end
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_errors++; $display("FAIL rand_timeout got %0d pending exp 0", exp_q.size());
    end
    exp_q.delete();
    tick(); i_ready = 0; i_imem_ack = 0; i_pc_valid = 0;
    @(negedge clk);
    n_checks++;
    if ({o_valid, o_fetch_cnt} !== {1'b0, exp_cnt}) begin
      n_errors++; $display("FAIL rand_final got v=%b cnt=%0d exp 0 %0d", o_valid, o_fetch_cnt, exp_cnt);
    end
  endtask

  task automatic test_wrap_and_reset();
    // Stand in for 65534 earlier deliveries by depositing the count directly.
    tick();
    dut.fetch_cnt_q = 16'hFFFE;
    exp_cnt = 16'hFFFE;
    for (int k = 0; k < 2; k++) begin
      tick(); i_pc = 32'h40 + 32'(k * 4); i_pc_valid = 1; i_ready = 1;
      tick(); i_pc_valid = 0; i_imem_ack = 1; i_imem_rdata = mem_word(32'h40);
      tick(); i_imem_ack = 0;
      tick(); i_ready = 0; exp_cnt++;
      @(negedge clk);
      n_checks++;
      if (o_fetch_cnt !== exp_cnt) begin
        n_errors++; $display("FAIL wrap_cnt k%0d got %h exp %h", k, o_fetch_cnt, exp_cnt);
      end
    end
    tick(); i_pc = 32'h50; i_pc_valid = 1;
    tick(); i_pc_valid = 0;
    #2 rst = 1'b0;
    #1;
    n_checks++;
    if ({o_imem_req, o_valid, o_fault, o_imem_addr, o_instr, o_instr_pc, o_fetch_cnt} !==
        {3'b000, 32'h0, 32'h0, RST_PC, 16'h0}) begin
      n_errors++; $display("FAIL async_reset got req=%b v=%b f=%b addr=%h instr=%h pc=%h cnt=%0d", o_imem_req, o_valid, o_fault, o_imem_addr, o_instr, o_instr_pc, o_fetch_cnt);
    end
    exp_cnt = 16'd0;
    tick(); tick(); rst = 1'b1;
    tick();
    @(negedge clk);
    n_checks++;
    if ({o_imem_req, o_valid, o_pc_ready} !== 3'b001) begin
      n_errors++; $display("FAIL reset_no_drain got req=%b v=%b rdy=%b exp 0 0 1", o_imem_req, o_valid, o_pc_ready);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_back_to_back();
    test_fault();
    test_flush();
    test_random();
    test_wrap_and_reset();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/single_ifetch.md
SINGLE_IFETCH -- requirements
Module: single_ifetch

Interface
REQ-001 Parameter N, default 32, SHALL set the width of the data and address paths.
REQ-002 Parameter RESET_PC, default 32'h0000_0000, SHALL be the reset value of o_instr_pc.
REQ-003 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-004 clk  in  1  rising-edge clock.
REQ-005 rst  in  1  asynchronous, active-low reset.
REQ-006 i_pc  in  N  fetch address from the PC stage.
REQ-007 i_pc_valid  in  1  i_pc is presented for fetch.
REQ-008 o_pc_ready  out  1  the fetch address is accepted this cycle.
REQ-009 o_imem_req  out  1  instruction-memory request.
REQ-010 o_imem_addr  out  N  instruction-memory address.
REQ-011 i_imem_ack  in  1  memory completes the request; i_imem_rdata is valid.
REQ-012 i_imem_rdata  in  N  instruction word.
REQ-013 o_valid  out  1  the instruction is presented to decode.
REQ-014 i_ready  in  1  decode accepts the instruction.
REQ-015 o_instr, o_instr_pc  out  N each  instruction word and its address.
REQ-016 o_fault  out  1  the presented entry is a misaligned-fetch fault.
REQ-017 i_flush  in  1  discards all in-flight fetch work.
REQ-018 o_fetch_cnt  out  16  count of delivered non-fault instructions.

Function
REQ-019 The FSM SHALL have exactly four states: IDLE, REQ, FULL and DRAIN.
REQ-020 o_pc_ready SHALL be 1 when state==IDLE, or when state==FULL with i_ready=1, and i_flush=0 in either case; it SHALL be 0 otherwise.
REQ-021 On accept (i_pc_valid && o_pc_ready), the block SHALL latch i_pc into o_imem_addr and o_instr_pc.
REQ-022 On an accept with i_pc[1:0]!=0, the block SHALL enter FULL with o_fault=1 and o_instr=32'h0000_0000, and SHALL issue no memory request.
REQ-023 On an accept with i_pc[1:0]==0, the block SHALL enter REQ, with o_imem_req=1 from the next cycle.
REQ-024 In REQ, o_imem_req and o_imem_addr SHALL stay stable until i_imem_ack.
REQ-025 On i_imem_ack in REQ, the block SHALL capture i_imem_rdata into o_instr, set o_fault=0 and enter FULL; o_imem_req SHALL be 0 in the next cycle.
REQ-026 Minimum latency from accept to o_valid SHALL be 2 cycles (ack arriving in the first request cycle).
REQ-027 o_valid SHALL be 1 only in FULL; o_instr, o_instr_pc and o_fault SHALL hold while o_valid && !i_ready.
REQ-028 In FULL with i_ready=1, the entry SHALL transfer; the next state SHALL be REQ or FULL(fault) on a simultaneous accept, else IDLE (zero-bubble back-to-back).
REQ-029 i_flush in IDLE or FULL SHALL force IDLE at the next edge; the held entry SHALL be dropped and SHALL not be counted.
REQ-030 i_flush in REQ SHALL enter DRAIN; in DRAIN, o_imem_req SHALL stay 1 until i_imem_ack, the data SHALL be discarded, and the next state SHALL be IDLE.
REQ-031 i_flush in DRAIN SHALL have no additional effect.
REQ-032 i_imem_ack outside REQ/DRAIN SHALL be ignored.
REQ-033 o_fetch_cnt SHALL increment by 1 on each o_valid && i_ready && !o_fault && !i_flush, and SHALL wrap from 16'hFFFF to 0.

Reset
REQ-034 While rst=0, the block SHALL force: state IDLE; o_imem_req 0; o_imem_addr 0; o_instr 0; o_instr_pc RESET_PC; o_fault 0; o_valid 0; o_fetch_cnt 0.
REQ-035 A reset asserted mid-request SHALL abandon the request, with no DRAIN.
REQ-036 Memory SHALL be reset by the same rst.

Structure
REQ-037 The state encoding (2-bit) and the NOP constant SHALL reside in shared package single_cpu_pkg.
REQ-038 The block SHALL be a single module with no sub-module; the counter and FSM are inline.

Verification
REQ-039 Bench SHALL check: reset release, i_pc=32'h0000_0010 valid, ack after 3 cycles with rdata=32'h2002_0005 -> o_valid after ack edge, o_instr_pc=32'h10, o_fetch_cnt=1 after i_ready.
REQ-040 Bench SHALL check: i_ready held 0 for 4 cycles in FULL -> outputs stable, o_pc_ready=0, no new o_imem_req.
REQ-041 Bench SHALL check: back-to-back PCs 0x0, 0x4, 0x8 with same-cycle ack and i_ready=1 -> one instruction per 2 cycles, no lost or duplicated entries.
REQ-042 Bench SHALL check: i_pc=32'h0000_0006 -> o_fault=1, o_instr=0, o_imem_req never 1, o_fetch_cnt unchanged.
REQ-043 Bench SHALL check: i_flush during REQ, ack 2 cycles later with rdata=32'hDEAD_BEEF -> DRAIN, o_valid never 1, then IDLE with o_pc_ready=1.
REQ-044 Bench SHALL check: o_fetch_cnt preloaded via 65535 deliveries -> the next delivery gives 0; rst=0 mid-REQ -> all outputs take REQ-034 values asynchronously.
